apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB requester for the matmul APB slave. Accepts one request at a time
//  on a valid/ready port and runs a full APB SETUP->ACCESS transfer on the bus.
//  Captures prdata/pslverr and returns a single-cycle response pulse.
//  Bounds slave wait states with a timeout that converts a stall into an error response.
// PARAMETERS
//  DATA_WIDTH      32   matrix element width (carried for consistency; not used in datapath)
//  BUS_WIDTH       64   APB data bus width; pstrb width = BUS_WIDTH/8
//  ADDR_WIDTH      32   APB address width
//  TIMEOUT_CYCLES  16   max ACCESS cycles with pready_i low before timeout error (>=2)
// PORTS
//  clk_i        in   1             clock, rising edge
//  rst_i        in   1             asynchronous reset, active-high
//  req_valid_i  in   1             request present
//  req_ready_o  out  1             bridge can accept request (state==IDLE)
//  req_write_i  in   1             1=write, 0=read
//  req_addr_i   in   ADDR_WIDTH    target address
//  req_wdata_i  in   BUS_WIDTH     write data
//  req_strb_i   in   BUS_WIDTH/8   write byte strobes
//  rsp_valid_o  out  1             response pulse, exactly 1 cycle per accepted request
//  rsp_rdata_o  out  BUS_WIDTH     read data (0 for writes and for errors)
//  rsp_err_o    out  1             pslverr_i seen or timeout
//  psel_o       out  1             APB select
//  penable_o    out  1             APB enable
//  pwrite_o     out  1             APB direction
//  pstrb_o      out  BUS_WIDTH/8   APB strobes (forced 0 on reads)
//  pwdata_o     out  BUS_WIDTH     APB write data
//  paddr_o      out  ADDR_WIDTH    APB address
//  pready_i     in   1             APB slave ready
//  pslverr_i    in   1             APB slave error
//  prdata_i     in   BUS_WIDTH     APB read data
//  busy_o       out  1             state != IDLE
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, timeout counter=0.
//   All outputs 0, except req_ready_o=1 (decoded from IDLE).
//  FSM states: IDLE, SETUP, ACCESS, RESP. All APB/rsp outputs are registered.
//  IDLE: req_ready_o=1.
//   On req_valid_i at edge E: latch write/addr/wdata/strb (strb:=0 if read).
//   -> SETUP. After E: psel_o=1, penable_o=0, busy_o=1.
//   Request fields are ignored while req_ready_o=0.
//  SETUP: unconditional -> ACCESS. After E+1: psel_o=1, penable_o=1.
//   paddr/pwrite/pwdata/pstrb are held stable from SETUP through the end of ACCESS.
//  ACCESS: sample pready_i each edge.
//   pready_i=1 -> RESP. rsp_valid_o=1, rsp_err_o=pslverr_i.
//    rsp_rdata_o = prdata_i on an error-free read, else 0.
//    psel_o/penable_o drop to 0 at the same edge.
//   pready_i=0 -> counter++. If counter reaches TIMEOUT_CYCLES-1 with pready_i still 0:
//    -> RESP with rsp_err_o=1, rsp_rdata_o=0, psel/penable dropped.
//   Counter clears on ACCESS entry.
//  RESP: rsp_valid_o high for this one cycle -> IDLE. rsp_valid_o, rsp_err_o and
//   rsp_rdata_o clear to 0. The next request is acceptable one cycle after RESP.
//  Min latency with zero wait states: accept edge E -> rsp_valid_o high after E+2.
//   Back-to-back throughput: 1 transfer per 4 cycles.
//  pslverr_i/prdata_i are ignored outside ACCESS. pready_i high in SETUP has no effect.
//  Reset mid-transfer: bus released immediately (psel/penable=0), no response issued.
//  The bridge never re-issues a request; the requester owns retry policy.
// TESTING
//  1 Write addr=0x1, wdata=0xDEAD_BEEF_0000_0001, strb=0xFF, pready_i=1 in ACCESS
//    -> psel 1 cycle alone, then psel+penable; rsp_valid=1, err=0, rdata=0.
//  2 Read addr=0x1, prdata_i=0xDEAD_BEEF_0000_0001, pready_i after 3 waits
//    -> pstrb_o=0 throughout; rsp_rdata=0xDEAD_BEEF_0000_0001, err=0,
//       rsp 5 edges after accept.
//  3 Read with pslverr_i=1, pready_i=1 -> rsp_err=1, rsp_rdata=0, bus idle next cycle.
//  4 pready_i held 0, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles rsp_err=1,
//    psel/penable=0, req_ready=1 next cycle.
//  5 req_valid_i held high for two requests -> second accepted only after RESP;
//    exactly 2 rsp pulses; addr/data stable during each transfer.
//  6 Assert rst_i during ACCESS -> same cycle psel/penable/busy=0, no rsp_valid;
//    after release req_ready=1.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response port and APB bus of the APB master bridge, bundled into one interface.
// The master modport is the bridge's view; the slave modport is the requester plus APB slave.
interface apb_master_bridge_if #(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [BUS_WIDTH-1:0]  req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;

  logic                  rsp_valid_o;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o;

  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  pready_i;
  logic                  pslverr_i;
  logic [BUS_WIDTH-1:0]  prdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
    input  pready_i, pslverr_i, prdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
    output pready_i, pslverr_i, prdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready request in, SETUP->ACCESS transfer on the bus,
// one-cycle response pulse out. Slave stalls are bounded by a wait-state timeout.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  apb_master_bridge_if.master  bus,
  output logic                 busy_o
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || DATA_WIDTH < 1 || BUS_WIDTH % 8 != 0 || ADDR_WIDTH < 1) begin : g_bad_params
    $error("apb_master_bridge: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] timeout_cnt;

  // Ready and busy are pure decodes of the state register, so they change on the same edge.
  assign bus.req_ready_o = (state == IDLE);
  assign busy_o          = (state != IDLE);

  // NOTE: every state and output register here is written with <= so that all of them
  // update together from pre-edge values; a blocking = would leak same-cycle values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      timeout_cnt     <= '0;
      bus.psel_o      <= 1'b0;
      bus.penable_o   <= 1'b0;
      bus.pwrite_o    <= 1'b0;
      bus.pstrb_o     <= '0;
      bus.pwdata_o    <= '0;
      bus.paddr_o     <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.psel_o   <= 1'b1;
            bus.pwrite_o <= bus.req_write_i;
            bus.paddr_o  <= bus.req_addr_i;
            bus.pwdata_o <= bus.req_wdata_i;
            bus.pstrb_o  <= bus.req_write_i ? bus.req_strb_i : '0;
            state        <= SETUP;
          end
        end

        SETUP: begin
          bus.penable_o <= 1'b1;
          timeout_cnt   <= '0;
          state         <= ACCESS;
        end

        ACCESS: begin
          if (bus.pready_i) begin
            bus.psel_o      <= 1'b0;
            bus.penable_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= bus.pslverr_i;
            bus.rsp_rdata_o <= (!bus.pwrite_o && !bus.pslverr_i) ? bus.prdata_i : '0;
            state           <= RESP;
          end else if (timeout_cnt == CNT_LAST) begin
            // Slave stalled too long: abandon the transfer and report it as an error.
            bus.psel_o      <= 1'b0;
            bus.penable_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_rdata_o <= '0;
            state           <= RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        RESP: begin
          bus.rsp_valid_o <= 1'b0;
          bus.rsp_err_o   <= 1'b0;
          bus.rsp_rdata_o <= '0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// compared against a transaction-level model of latency, error and read data.
module tb_apb_master_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] nxt_addr;
  logic [63:0] nxt_wdata;
  logic [7:0]  nxt_strb;
  logic        nxt_write;

  apb_master_bridge_if #(.BUS_WIDTH(64), .ADDR_WIDTH(32)) bus_if ();

  apb_master_bridge #(
    .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus_if),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: a response arrives 2 edges after accept plus one per wait
  // state, unless the slave stalls for the whole timeout window, which yields an error.
  function automatic void model(input logic wr, input int waits, input logic slverr,
                                input logic [63:0] prdata, output int lat,
                                output logic err, output logic [63:0] rdata);
    if (waits >= TO) begin
      lat = 1 + TO; err = 1'b1; rdata = '0;
    end else begin
      lat = 2 + waits; err = slverr; rdata = (!wr && !slverr) ? prdata : 64'h0;
    end
  endfunction

  task automatic check_fields(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [7:0] strb);
    check({tag, "_paddr"},  bus_if.paddr_o,  addr);
    check({tag, "_pwrite"}, bus_if.pwrite_o, wr);
    check({tag, "_pwdata"}, bus_if.pwdata_o, wdata);
    check({tag, "_pstrb"},  bus_if.pstrb_o,  strb);
  endtask

  // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle again.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input int waits, input logic slverr,
                      input logic [63:0] prdata, input logic hold);
    int lat;
    int exp_lat;
    logic exp_err;
    logic [63:0] exp_rdata;
    logic [7:0] exp_strb;
    bit seen;
    model(wr, waits, slverr, prdata, exp_lat, exp_err, exp_rdata);
    exp_strb = wr ? strb : 8'h00;

    bus_if.req_valid_i = 1'b1;
    bus_if.req_write_i = wr;
    bus_if.req_addr_i  = addr;
    bus_if.req_wdata_i = wdata;
    bus_if.req_strb_i  = strb;
    check("idle_ready", bus_if.req_ready_o, 1'b1);
    @(posedge clk); @(negedge clk);

    if (hold) begin
      bus_if.req_write_i = nxt_write;
      bus_if.req_addr_i  = nxt_addr;
      bus_if.req_wdata_i = nxt_wdata;
      bus_if.req_strb_i  = nxt_strb;
    end else begin
      bus_if.req_valid_i = 1'b0;
      bus_if.req_write_i = 1'($urandom);
      bus_if.req_addr_i  = $urandom;
      bus_if.req_wdata_i = {$urandom, $urandom};
      bus_if.req_strb_i  = 8'($urandom);
    end
    check("setup_psel", bus_if.psel_o, 1'b1);
    check("setup_penable", bus_if.penable_o, 1'b0);
    check("setup_busy", busy, 1'b1);
    check("setup_ready", bus_if.req_ready_o, 1'b0);
    check_fields("setup", wr, addr, wdata, exp_strb);

    // Ready and error noise during SETUP must not shorten the transfer.
    bus_if.pready_i  = 1'b1;
    bus_if.pslverr_i = 1'b1;
    bus_if.prdata_i  = {$urandom, $urandom};
    lat = 1;
    @(posedge clk); @(negedge clk);
    check("access_psel", bus_if.psel_o, 1'b1);
    check("access_penable", bus_if.penable_o, 1'b1);
    check("access_rsp_valid", bus_if.rsp_valid_o, 1'b0);

    seen = 1'b0;
    for (int k = 0; k < TO + 4 && !seen; k++) begin
      bus_if.pready_i  = (k == waits);
      bus_if.pslverr_i = (k == waits) ? slverr : 1'($urandom);
      bus_if.prdata_i  = (k == waits) ? prdata : {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus_if.rsp_valid_o) seen = 1'b1;
      else begin
        check("wait_penable", bus_if.penable_o, 1'b1);
        check_fields("wait", wr, addr, wdata, exp_strb);
      end
    end
    check("rsp_seen", seen, 1'b1);
    check("rsp_latency", lat, exp_lat);
    check("rsp_err", bus_if.rsp_err_o, exp_err);
    check("rsp_rdata", bus_if.rsp_rdata_o, exp_rdata);
    check("resp_psel", bus_if.psel_o, 1'b0);
    check("resp_penable", bus_if.penable_o, 1'b0);
    check("resp_busy", busy, 1'b1);

    bus_if.pready_i  = 1'b0;
    bus_if.pslverr_i = 1'b0;
    bus_if.prdata_i  = '0;
    @(posedge clk); @(negedge clk);
    check("post_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    check("post_rsp_err", bus_if.rsp_err_o, 1'b0);
    check("post_rsp_rdata", bus_if.rsp_rdata_o, 64'h0);
    check("post_ready", bus_if.req_ready_o, 1'b1);
    check("post_busy", busy, 1'b0);
    check("post_psel", bus_if.psel_o, 1'b0);
  endtask

  initial begin
    bus_if.req_valid_i = 1'b0;
    bus_if.req_write_i = 1'b0;
    bus_if.req_addr_i  = '0;
    bus_if.req_wdata_i = '0;
    bus_if.req_strb_i  = '0;
    bus_if.pready_i    = 1'b0;
    bus_if.pslverr_i   = 1'b0;
    bus_if.prdata_i    = '0;
    nxt_addr = '0; nxt_wdata = '0; nxt_strb = '0; nxt_write = 1'b0;

    // Reset state
    #1;
    check("rst_ready", bus_if.req_ready_o, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_psel", bus_if.psel_o, 1'b0);
    check("rst_penable", bus_if.penable_o, 1'b0);
    check("rst_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    check("rst_paddr", bus_if.paddr_o, 32'h0);
    check("rst_pstrb", bus_if.pstrb_o, 8'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write
    xfer(1'b1, 32'h1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    // Read with three wait states, junk strobes must be dropped
    xfer(1'b0, 32'h1, 64'h5555_AAAA_5555_AAAA, 8'hA5, 3, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    // Read answered with slave error
    xfer(1'b0, 32'h40, 64'h0, 8'h0F, 0, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b0);
    // Slave never ready: timeout error
    xfer(1'b0, 32'h80, 64'h0, 8'h00, 1000, 1'b0, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
    // Ready on the last permitted wait cycle still completes normally
    xfer(1'b0, 32'h84, 64'h0, 8'h00, TO - 1, 1'b0, 64'h0BAD_CAFE_0000_00FF, 1'b0);

    // Request held valid across two transfers; second fields must not disturb the first
    nxt_write = 1'b1; nxt_addr = 32'hB0; nxt_wdata = 64'h0102_0304_0506_0708; nxt_strb = 8'h3C;
    xfer(1'b0, 32'hA0, 64'h0, 8'hFF, 1, 1'b0, 64'h1111_2222_3333_4444, 1'b1);
    xfer(nxt_write, nxt_addr, nxt_wdata, nxt_strb, 0, 1'b0, 64'h0, 1'b0);

    // Randomized transfers, back to back
    for (int n = 0; n < 40; n++) begin
      int r;
      int w;
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? (r % 5) : ((r == 7) ? TO - 1 : ((r == 8) ? TO : TO + 9));
      xfer(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom), w,
           ($urandom_range(0, 3) == 0), {$urandom, $urandom}, 1'b0);
    end

    // Reset during ACCESS releases the bus at once and produces no response
    bus_if.req_valid_i = 1'b1;
    bus_if.req_write_i = 1'b1;
    bus_if.req_addr_i  = 32'hC0;
    bus_if.req_wdata_i = 64'h7777_8888_9999_AAAA;
    bus_if.req_strb_i  = 8'hFF;
    @(posedge clk); @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_penable", bus_if.penable_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_psel", bus_if.psel_o, 1'b0);
    check("midrst_penable", bus_if.penable_o, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("after_rst_ready", bus_if.req_ready_o, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_rst_no_rsp", bus_if.rsp_valid_o, 1'b0);
      check("after_rst_no_psel", bus_if.psel_o, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
